phase_scheduler: RTL and testbench

- Demand-driven round-robin scheduler that shares the intersection's single green phase between four approaches: NS, SN, EW, WE.
- Per-approach demand comes from near (S1) and far (S5) loop sensors. Far-sensor occupancy extends green up to a hard maximum.
- Sequences GREEN -> YELLOW -> ALL_RED clearance and drives the four 2-bit light outputs.
- Sits between the sensor inputs and the light drivers.

---
 rtl/traffic_pkg.sv | 29 ++
 rtl/rr_picker.sv | 34 +++
 rtl/phase_scheduler.sv | 140 ++++++++++++++
 tb/tb_phase_scheduler.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// traffic_pkg: shared light codes, phase encodings and approach indices for
// the intersection phase scheduler.
package traffic_pkg;

   typedef enum logic [1:0] {
      LT_RED    = 2'b00,
      LT_YELLOW = 2'b01,
      LT_GREEN  = 2'b10
   } light_t;

   typedef enum logic [1:0] {
      PH_IDLE    = 2'd0,
      PH_GREEN   = 2'd1,
      PH_YELLOW  = 2'd2,
      PH_ALL_RED = 2'd3
   } phase_t;

   localparam int NUM_DIR = 4;

   localparam logic [1:0] DIR_NS = 2'd0;
   localparam logic [1:0] DIR_SN = 2'd1;
   localparam logic [1:0] DIR_EW = 2'd2;
   localparam logic [1:0] DIR_WE = 2'd3;

   function automatic logic [NUM_DIR-1:0] dir_onehot(input logic [1:0] dir);
      return 4'b0001 << dir;
   endfunction

endpackage

// File: rtl/rr_picker.sv
// rr_picker: combinational round-robin selector over the four approaches.
//   d    in  4  per-approach demand
//   ptr  in  2  last approach granted; scanning starts at ptr+1
//   pick out 2  first demanding approach at or after ptr+1 (wrapping)
//   any  out 1  at least one approach demands
// When only the ptr approach demands, the scan wraps back to it.
module rr_picker
   import traffic_pkg::*;
(
   input  logic [NUM_DIR-1:0] d,
   input  logic [1:0]         ptr,
   output logic [1:0]         pick,
   output logic               any
);

   logic       found;
   logic [1:0] idx;

   always_comb begin
      pick  = ptr;
      found = 1'b0;
      idx   = ptr;
      for (int k = 1; k <= NUM_DIR; k++) begin
         idx = ptr + 2'(k);
         if (!found && d[idx]) begin
            pick  = idx;
            found = 1'b1;
         end
      end
   end

   assign any = |d;

endmodule

// File: rtl/phase_scheduler.sv
// phase_scheduler: demand-driven round-robin owner of the single green phase
// shared by approaches NS, SN, EW, WE. Sequences GREEN -> YELLOW -> ALL_RED.
//   clk, rst              clock, asynchronous active-high reset
//   req_near, req_far     S1 / S5 loop sensors (bit 0=NS,1=SN,2=EW,3=WE)
//   grant                 one-hot approach in GREEN or YELLOW, else 0
//   phase_state           IDLE=0, GREEN=1, YELLOW=2, ALL_RED=3
//   NS/SN/EW/WE_light     RED=00, YELLOW=01, GREEN=10
// Optional: EMERGENCY_PREEMPT_EN adds preempt / preempt_dir, which force the
// green onto preempt_dir without ever shortening yellow or all-red.
module phase_scheduler
   import traffic_pkg::*;
#(
   parameter int MIN_GREEN = 4,
   parameter int MAX_GREEN = 12,
   parameter int YELLOW_T  = 2,
   parameter int ALLRED_T  = 1,
   parameter int CNT_W     = 5
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_DIR-1:0] req_near,
   input  logic [NUM_DIR-1:0] req_far,
`ifdef EMERGENCY_PREEMPT_EN
   input  logic               preempt,
   input  logic [1:0]         preempt_dir,
`endif
   output logic [NUM_DIR-1:0] grant,
   output logic [1:0]         phase_state,
   output logic [1:0]         NS_light,
   output logic [1:0]         SN_light,
   output logic [1:0]         EW_light,
   output logic [1:0]         WE_light
);

   localparam logic [CNT_W-1:0] MIN_LAST = CNT_W'(MIN_GREEN - 1);
   localparam logic [CNT_W-1:0] MAX_LAST = CNT_W'(MAX_GREEN - 1);
   localparam logic [CNT_W-1:0] Y_LAST   = CNT_W'(YELLOW_T - 1);
   localparam logic [CNT_W-1:0] AR_LAST  = CNT_W'(ALLRED_T - 1);

   phase_t             state;
   logic [CNT_W-1:0]   timer;
   logic [1:0]         ptr;
   logic [1:0]         gdir;
   logic [NUM_DIR-1:0] grant_q;
   light_t             lights_q [NUM_DIR];

   logic [NUM_DIR-1:0] d;
   logic [1:0]         pick;
   logic               any;
   logic               other;
   logic               pre_act;
   logic [1:0]         pre_dir;
   logic               pre_hold;
   logic               start;
   logic [1:0]         sel_dir;

   assign d     = req_near | req_far;
   assign other = |(d & ~dir_onehot(gdir));

`ifdef EMERGENCY_PREEMPT_EN
   assign pre_act = preempt;
   assign pre_dir = preempt_dir;
`else
   assign pre_act = 1'b0;
   assign pre_dir = DIR_NS;
`endif

   // Preemption on the approach already green freezes the phase in place.
   assign pre_hold = pre_act && (gdir == pre_dir);
   assign start    = pre_act | any;
   assign sel_dir  = pre_act ? pre_dir : pick;

   rr_picker u_rr_picker (
      .d    (d),
      .ptr  (ptr),
      .pick (pick),
      .any  (any)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= PH_IDLE;
         timer   <= '0;
         ptr     <= DIR_WE;
         gdir    <= DIR_NS;
         grant_q <= '0;
         for (int i = 0; i < NUM_DIR; i++) lights_q[i] <= LT_RED;
      end else begin
         unique case (state)
            PH_IDLE, PH_ALL_RED: begin
               if (state == PH_ALL_RED && timer != AR_LAST) begin
                  timer <= timer + 1'b1;
               end else if (start) begin
                  // All lights are already RED here, so only the winner changes.
                  state             <= PH_GREEN;
                  timer             <= '0;
                  gdir              <= sel_dir;
                  ptr               <= sel_dir;
                  grant_q           <= dir_onehot(sel_dir);
                  lights_q[sel_dir] <= LT_GREEN;
               end else begin
                  state <= PH_IDLE;
                  timer <= '0;
               end
            end
            PH_GREEN: begin
               if (pre_hold) begin
                  timer <= timer;
               end else if (pre_act ||
                            (other && ((timer >= MIN_LAST && !req_far[gdir]) ||
                                       timer == MAX_LAST))) begin
                  state          <= PH_YELLOW;
                  timer          <= '0;
                  lights_q[gdir] <= LT_YELLOW;
               end else if (timer != MAX_LAST) begin
                  timer <= timer + 1'b1;
               end
            end
            PH_YELLOW: begin
               if (timer == Y_LAST) begin
                  state          <= PH_ALL_RED;
                  timer          <= '0;
                  grant_q        <= '0;
                  lights_q[gdir] <= LT_RED;
               end else begin
                  timer <= timer + 1'b1;
               end
            end
         endcase
      end
   end

   assign grant       = grant_q;
   assign phase_state = state;
   assign NS_light    = lights_q[DIR_NS];
   assign SN_light    = lights_q[DIR_SN];
   assign EW_light    = lights_q[DIR_EW];
   assign WE_light    = lights_q[DIR_WE];

endmodule

// File: tb/tb_phase_scheduler.sv
// Scoreboard bench for phase_scheduler: a driver issues stimulus on the falling
// edge, advances a behavioural model and queues the expected outputs; a monitor
// checks them one step after each rising edge.
module tb_phase_scheduler;

   localparam int MIN_GREEN = 4;
   localparam int MAX_GREEN = 12;
   localparam int YELLOW_T  = 2;
   localparam int ALLRED_T  = 1;

   typedef struct packed {
      logic [1:0] st;
      logic [3:0] gr;
      logic [7:0] lt;   // {WE, EW, SN, NS}
   } obs_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] req_near = '0;
   logic [3:0] req_far  = '0;
`ifdef EMERGENCY_PREEMPT_EN
   logic       preempt = 1'b0;
   logic [1:0] preempt_dir = '0;
`endif
   logic [3:0] grant;
   logic [1:0] phase_state;
   logic [1:0] NS_light, SN_light, EW_light, WE_light;

   phase_scheduler dut (
      .clk         (clk),
      .rst         (rst),
      .req_near    (req_near),
      .req_far     (req_far),
`ifdef EMERGENCY_PREEMPT_EN
      .preempt     (preempt),
      .preempt_dir (preempt_dir),
`endif
      .grant       (grant),
      .phase_state (phase_state),
      .NS_light    (NS_light),
      .SN_light    (SN_light),
      .EW_light    (EW_light),
      .WE_light    (WE_light)
   );

   always #5 clk = ~clk;

   int   n_checks = 0;
   int   n_fail   = 0;
   obs_t exp_q [$];

   // Reference model: phase 0 idle, 1 green, 2 yellow, 3 all-red; m_age counts
   // cycles the current phase has been shown (1 on entry).
   int m_phase, m_dir, m_ptr, m_age;

   function automatic obs_t dut_obs();
      return {phase_state, grant, WE_light, EW_light, SN_light, NS_light};
   endfunction

   task automatic check_obs(input string name, input obs_t got, input obs_t exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s t=%0t: got st=%0d grant=%b lights=%b, expected st=%0d grant=%b lights=%b",
                  name, $time, got.st, got.gr, got.lt, exp.st, exp.gr, exp.lt);
      end
   endtask

   function automatic obs_t model_obs();
      obs_t o;
      o.st = 2'(m_phase);
      o.gr = '0;
      o.lt = '0;
      if (m_phase == 1 || m_phase == 2) begin
         o.gr[m_dir] = 1'b1;
         o.lt[2*m_dir +: 2] = (m_phase == 1) ? 2'b10 : 2'b01;
      end
      return o;
   endfunction

   task automatic model_reset();
      m_phase = 0; m_dir = 0; m_ptr = 3; m_age = 0;
   endtask

   function automatic int rr_next(input logic [3:0] d);
      for (int k = 1; k <= 4; k++) begin
         int c;
         c = (m_ptr + k) % 4;
         if (d[c]) return c;
      end
      return -1;
   endfunction

   task automatic enter(input int p, input int dir);
      m_phase = p; m_dir = dir; m_age = 1;
      if (p == 1) m_ptr = dir;
   endtask

   task automatic model_step(input logic [3:0] near, input logic [3:0] far);
      logic [3:0] d;
      logic [3:0] mine;
      int nxt;
      d = near | far;
      mine = '0;
      mine[m_dir] = 1'b1;
      case (m_phase)
         0: begin
            nxt = rr_next(d);
            if (nxt >= 0) enter(1, nxt);
         end
         1: begin
            if ((d & ~mine) != 0 &&
                ((m_age >= MIN_GREEN && !far[m_dir]) || m_age >= MAX_GREEN))
               enter(2, m_dir);
            else m_age++;
         end
         2: if (m_age >= YELLOW_T) enter(3, m_dir); else m_age++;
         default: begin
            if (m_age >= ALLRED_T) begin
               nxt = rr_next(d);
               if (nxt >= 0) enter(1, nxt); else enter(0, 0);
            end else m_age++;
         end
      endcase
   endtask

   task automatic step(input logic [3:0] near, input logic [3:0] far);
      @(negedge clk);
      req_near = near;
      req_far  = far;
      model_step(near, far);
      exp_q.push_back(model_obs());
   endtask

   // Reset asserted between edges must clear outputs before any clock edge.
   task automatic pulse_reset(input string name);
      @(negedge clk);
      req_near = '0;
      req_far  = '0;
      #2 rst = 1'b1;
      #1 check_obs(name, dut_obs(), obs_t'(0));
      exp_q.push_back(obs_t'(0));
      @(negedge clk);
      rst = 1'b0;
      model_reset();
   endtask

   // Monitor: compare queued expectations and the light invariants.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) check_obs("outputs", dut_obs(), exp_q.pop_front());
         begin
            int nonred;
            logic [3:0] lit;
            nonred = 0;
            lit = '0;
            for (int i = 0; i < 4; i++) begin
               logic [1:0] code;
               code = dut_obs().lt[2*i +: 2];
               if (code != 2'b00) begin nonred++; lit[i] = 1'b1; end
            end
            n_checks++;
            if (nonred > 1 || lit !== grant) begin
               n_fail++;
               $display("FAIL invariant t=%0t: non-red=%0d lit=%b grant=%b", $time, nonred, lit, grant);
            end
         end
      end
   end

   initial begin
      int hold;
      int waited;
      logic [3:0] rn, rf;
      model_reset();
      #1 check_obs("reset_initial", dut_obs(), obs_t'(0));
      exp_q.push_back(obs_t'(0));
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 3; i++) step(4'b0000, 4'b0000);        // idle hold
      for (int i = 0; i < 55; i++) step(4'b0001, 4'b0000);       // NS rests in green
      pulse_reset("reset_between_edges");
      step(4'b0001, 4'b0000);
      for (int i = 0; i < 20; i++) step(4'b0101, 4'b0000);       // yield at minimum
      pulse_reset("reset_before_far");
      step(4'b0001, 4'b0000);
      for (int i = 0; i < 30; i++) step(4'b0010, 4'b0001);       // far extension
      pulse_reset("reset_before_fair");
      for (int i = 0; i < 60; i++) step(4'b1111, 4'b0000);       // fairness

      // Reset in the middle of a yellow phase.
      waited = 0;
      while (m_phase != 2 && waited < 40) begin
         step(4'b1111, 4'b0000);
         waited++;
      end
      n_checks++;
      if (m_phase != 2) begin
         n_fail++;
         $display("FAIL reach_yellow: model phase %0d, required 2", m_phase);
      end
      pulse_reset("reset_mid_yellow");
      step(4'b1010, 4'b0000);
      @(posedge clk);
      #2;
      n_checks++;
      if (grant !== 4'b0010) begin
         n_fail++;
         $display("FAIL first_after_reset: grant=%b, required 0010", grant);
      end
      for (int i = 0; i < 8; i++) step(4'b1010, 4'b0000);

      // Randomised demand with held intervals.
      rn = '0; rf = '0; hold = 0;
      for (int i = 0; i < 600; i++) begin
         if (hold == 0) begin
            rn = 4'($urandom_range(0, 15));
            rf = 4'($urandom) & 4'($urandom);
            hold = $urandom_range(1, 12);
         end
         hold--;
         step(rn, rf);
         if (i == 300) pulse_reset("reset_random");
      end

      @(posedge clk);
      #3;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
